// File: rtl/oa22_bist_pkg.sv
// Shared types and constants for the OA22 cell BIST controller.
//   state_t     : controller FSM states
//   VEC_LAST    : final input vector of a pass
//   oa22_expect : reference truth of a good OA22 cell, q = (i0 | i1) & i2
package oa22_bist_pkg;

    localparam int unsigned VEC_W = 3;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

    function automatic logic oa22_expect(input logic [VEC_W-1:0] v);
        return (v[0] | v[1]) & v[2];
    endfunction

endpackage

// File: rtl/oa22_bist_settle_cnt.sv
// Drive-phase settle timer: counts cycles spent driving one vector.
//   ck        : clock
//   rst       : synchronous active-high reset
//   load      : restart the count (asserted on the cycle that enters DRIVE)
//   en        : high while in DRIVE
//   expired_c : combinational, high on the last of SETTLE drive cycles
module oa22_bist_settle_cnt
    import oa22_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic ck,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt;

    // Count drive cycles; cleared whenever a new vector is about to be driven.
    always_ff @(posedge ck) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = en && (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/oa22_bist_ctrl.sv
// Exhaustive BIST controller for a single OA22 cell: walks vec 0..7, holds
// each vector SETTLE cycles, samples q_i once, and counts mismatches.
//   ck, rst          : clock, synchronous active-high reset
//   start            : one-cycle pass request (ignored unless idle)
//   i0_o, i1_o, i2_o : drives to the cell under test
//   q_i              : cell output
//   busy, done       : pass running / one-cycle end-of-pass pulse
//   pass, err_cnt    : result and mismatch count of the last pass
// Optional macro OA22_BIST_FAILLOG_EN adds fail_vec/fail_vld, the first
// failing vector of the pass.
module oa22_bist_ctrl
    import oa22_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    output logic             i0_o,
    output logic             i1_o,
    output logic             i2_o,
    input  logic             q_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef OA22_BIST_FAILLOG_EN
    ,
    output logic [VEC_W-1:0] fail_vec,
    output logic             fail_vld
`endif
);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic             settle_load_c;
    logic             settle_exp_c;
    logic             mismatch_c;
    logic [ERR_W-1:0] err_nxt_c;

    // A new vector starts driving on a start from idle or after a non-final check.
    assign settle_load_c = ((state == IDLE) && start) ||
                           ((state == CHECK) && (vec != VEC_LAST));

    assign mismatch_c = (state == CHECK) && (q_i != oa22_expect(vec));
    // Saturate rather than wrap; a pass cannot exceed 8 anyway.
    assign err_nxt_c  = (mismatch_c && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

    oa22_bist_settle_cnt #(
        .SETTLE(SETTLE)
    ) u_settle (
        .ck       (ck),
        .rst      (rst),
        .load     (settle_load_c),
        .en       (state == DRIVE),
        .expired_c(settle_exp_c)
    );

    // Controller FSM with registered outputs.
    always_ff @(posedge ck) begin
        if (rst) begin
            state                <= IDLE;
            vec                  <= '0;
            err_cnt              <= '0;
            pass                 <= 1'b0;
            done                 <= 1'b0;
            busy                 <= 1'b0;
            {i2_o, i1_o, i0_o}   <= '0;
`ifdef OA22_BIST_FAILLOG_EN
            fail_vec             <= '0;
            fail_vld             <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state              <= DRIVE;
                        vec                <= '0;
                        err_cnt            <= '0;
                        busy               <= 1'b1;
                        {i2_o, i1_o, i0_o} <= '0;
`ifdef OA22_BIST_FAILLOG_EN
                        fail_vec           <= '0;
                        fail_vld           <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    if (settle_exp_c) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_cnt <= err_nxt_c;
`ifdef OA22_BIST_FAILLOG_EN
                    if (mismatch_c && !fail_vld) begin
                        fail_vec <= vec;
                        fail_vld <= 1'b1;
                    end
`endif
                    if (vec == VEC_LAST) begin
                        state              <= DONE;
                        busy               <= 1'b0;
                        done               <= 1'b1;
                        pass               <= (err_nxt_c == '0);
                        {i2_o, i1_o, i0_o} <= '0;
                    end else begin
                        state              <= DRIVE;
                        vec                <= vec + VEC_W'(1);
                        {i2_o, i1_o, i0_o} <= vec + VEC_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
